// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, reset PC,
// chip-enable levels and stall-vector bit positions.
package if_stage_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;
   localparam int STALL_W     = 6;

   typedef logic [INST_ADDR_W-1:0] inst_addr_t;
   typedef logic [INST_W-1:0]      inst_t;

   localparam inst_t      ZERO_WORD    = '0;
   localparam inst_addr_t ZERO_ADDR    = '0;
   localparam logic       CHIP_ENABLE  = 1'b1;
   localparam logic       CHIP_DISABLE = 1'b0;
   localparam inst_addr_t RESET_PC     = '0;
   localparam inst_addr_t PC_STEP      = inst_addr_t'(4);

   localparam int STALL_PC = 0;
   localparam int STALL_IF = 1;
   localparam int STALL_ID = 2;

   // Instruction words are 4-byte aligned; any low address bit set is an error.
   function automatic logic pc_misaligned(input inst_addr_t pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its surroundings: pipeline control
// inputs, the instruction-ROM port and the IF/ID register outputs.
interface if_stage_if;
   import if_stage_pkg::*;

   logic [STALL_W-1:0] stall;
   logic               flush;
   inst_addr_t         new_pc;
   logic               branch_flag_i;
   inst_addr_t         branch_target_i;
   logic               rom_ce_o;
   inst_addr_t         rom_addr_o;
   inst_t              rom_data_i;
   inst_addr_t         id_pc_o;
   inst_t              id_inst_o;
   logic               id_adel_o;

   // Fetch-stage side.
   modport master (
      input  stall, flush, new_pc, branch_flag_i, branch_target_i, rom_data_i,
      output rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_adel_o
   );

   // Environment side (control unit, ROM, decode stage).
   modport slave (
      output stall, flush, new_pc, branch_flag_i, branch_target_i, rom_data_i,
      input  rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_adel_o
   );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. Flush clears it, a stall of IF with ID running
// inserts a bubble, a free IF captures the fetched word, otherwise it holds.
// A fetch with the ROM disabled is captured as an all-zero instruction.
module if_id_reg
   import if_stage_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       stall_if,
   input  logic       stall_id,
   input  logic       if_ce,
   input  inst_addr_t if_pc,
   input  inst_t      if_inst,
   input  logic       if_adel,
   output inst_addr_t id_pc,
   output inst_t      id_inst,
   output logic       id_adel
);

   inst_addr_t id_pc_q,   id_pc_d;
   inst_t      id_inst_q, id_inst_d;
   logic       id_adel_q, id_adel_d;

   // Next IF/ID contents by flush > bubble > capture > hold priority.
   always_comb begin
      id_pc_d   = id_pc_q;
      id_inst_d = id_inst_q;
      id_adel_d = id_adel_q;
      if (flush || (stall_if && !stall_id)) begin
         id_pc_d   = ZERO_ADDR;
         id_inst_d = ZERO_WORD;
         id_adel_d = 1'b0;
      end else if (!stall_if) begin
         id_pc_d   = if_pc;
         id_inst_d = (if_ce == CHIP_ENABLE) ? if_inst : ZERO_WORD;
         id_adel_d = if_adel;
      end
   end

   // Register with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_pc_q   <= ZERO_ADDR;
         id_inst_q <= ZERO_WORD;
         id_adel_q <= 1'b0;
      end else begin
         id_pc_q   <= id_pc_d;
         id_inst_q <= id_inst_d;
         id_adel_q <= id_adel_d;
      end
   end

   assign id_pc   = id_pc_q;
   assign id_inst = id_inst_q;
   assign id_adel = id_adel_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, ROM enable and the IF/ID register.
// The ROM is enabled one edge after reset release; the PC only moves once
// the ROM is enabled, with flush > stall > branch > sequential priority.
// Optional build macro FETCH_ALIGN_CHECK_EN: a misaligned PC disables the
// ROM for that cycle and is passed to ID as an address-error fetch.
module if_stage
   import if_stage_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   if_stage_if.master    bus
);

   logic       ce_q, ce_d;
   inst_addr_t pc_q, pc_d;
   logic       fetch_ce;
   logic       fetch_adel;
   logic       unused_stall;

   // Stall bits above ID belong to later stages.
   assign unused_stall = ^bus.stall[STALL_W-1:STALL_ID+1];

   // Next PC; held at reset value until the ROM has been enabled.
   always_comb begin
      ce_d = CHIP_ENABLE;
      pc_d = pc_q;
      if (ce_q == CHIP_ENABLE) begin
         if (bus.flush)
            pc_d = bus.new_pc;
         else if (bus.stall[STALL_PC])
            pc_d = pc_q;
         else if (bus.branch_flag_i)
            pc_d = bus.branch_target_i;
         else
            pc_d = pc_q + PC_STEP;
      end
   end

   // PC and ROM-enable registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ce_q <= CHIP_DISABLE;
         pc_q <= RESET_PC;
      end else begin
         ce_q <= ce_d;
         pc_q <= pc_d;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   assign fetch_adel = (ce_q == CHIP_ENABLE) && pc_misaligned(pc_q);
   assign fetch_ce   = fetch_adel ? CHIP_DISABLE : ce_q;
`else
   assign fetch_adel = 1'b0;
   assign fetch_ce   = ce_q;
`endif

   assign bus.rom_ce_o   = fetch_ce;
   assign bus.rom_addr_o = pc_q;

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .rst      (rst),
      .flush    (bus.flush),
      .stall_if (bus.stall[STALL_IF]),
      .stall_id (bus.stall[STALL_ID]),
      .if_ce    (fetch_ce),
      .if_pc    (pc_q),
      .if_inst  (bus.rom_data_i),
      .if_adel  (fetch_adel),
      .id_pc    (bus.id_pc_o),
      .id_inst  (bus.id_inst_o),
      .id_adel  (bus.id_adel_o)
   );

endmodule
